// File: rtl/echo_filter_mc_pkg.sv
// Shared constants and helpers for the multi-channel echo filter.
// Holds the default channel count, filter length, synchroniser depth and
// width-counter size, plus the helper that sizes the stability counter.
package echo_filter_mc_pkg;

   localparam int ECHO_N_CH        = 4;
   localparam int ECHO_FILT_LEN    = 16;
   localparam int ECHO_SYNC_STAGES = 2;
   localparam int ECHO_WIDTH_W     = 16;

   // Smallest counter width able to hold 0..len-1, never less than one bit.
   function automatic int cntWidth(input int len);
      int w;
      w = 1;
      while ((1 << w) < len) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/echo_filter_ch.sv
// One echo channel: input synchroniser, counter-based stability filter,
// registered rise/fall strobes and a saturating high-time counter.
module echo_filter_ch
   import echo_filter_mc_pkg::*;
#(
   parameter int FILT_LEN    = ECHO_FILT_LEN,
   parameter int SYNC_STAGES = ECHO_SYNC_STAGES,
   parameter int WIDTH_W     = ECHO_WIDTH_W
)
(
   input  logic               clk_sys,
   input  logic               rst,
   input  logic               en_i,
   input  logic               echo_i,
   output logic               lvl_o,
   output logic               rise_o,
   output logic               fall_o,
   output logic               vld_o,
   output logic [WIDTH_W-1:0] width_o,
   output logic               ovf_o
);

   localparam int                 CNT_W    = cntWidth(FILT_LEN);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FILT_LEN - 1);
   localparam logic [WIDTH_W-1:0] WCNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   syncOut;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   lvl_q, lvl_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   vld_q, vld_d;
   logic [WIDTH_W-1:0]     wcnt_q, wcnt_d;
   logic                   sat_q, sat_d;
   logic [WIDTH_W-1:0]     width_q, width_d;
   logic                   ovf_q, ovf_d;

   assign syncOut = sync_q[SYNC_STAGES-1];

   // Shift the raw asynchronous input through the synchroniser chain; it runs even when the channel is disabled.
   always_ff @(posedge clk_sys) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], echo_i};
   end

   // Decide the next filter count, level, strobes and width state from the synchronised sample.
   always_comb begin
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      vld_d   = 1'b0;
      wcnt_d  = wcnt_q;
      sat_d   = sat_q;
      width_d = width_q;
      ovf_d   = ovf_q;
      if (!en_i) begin
         cnt_d  = '0;
         lvl_d  = 1'b0;
         wcnt_d = '0;
         sat_d  = 1'b0;
      end else begin
         if (syncOut == lvl_q) begin
            cnt_d = '0;
         end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = '0;
            lvl_d = syncOut;
         end
         if (lvl_d && !lvl_q) begin
            rise_d = 1'b1;
            wcnt_d = WIDTH_W'(1);
            sat_d  = 1'b0;
         end else if (!lvl_d && lvl_q) begin
            fall_d  = 1'b1;
            vld_d   = 1'b1;
            width_d = wcnt_q;
            ovf_d   = sat_q;
         end else if (lvl_q) begin
            if (wcnt_q == WCNT_MAX) sat_d = 1'b1;
            else                    wcnt_d = wcnt_q + 1'b1;
         end
      end
   end

   // Register the filter, strobe and width state; reset clears everything including the last result.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         vld_q   <= 1'b0;
         wcnt_q  <= '0;
         sat_q   <= 1'b0;
         width_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         vld_q   <= vld_d;
         wcnt_q  <= wcnt_d;
         sat_q   <= sat_d;
         width_q <= width_d;
         ovf_q   <= ovf_d;
      end
   end

   assign lvl_o   = lvl_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign vld_o   = vld_q;
   assign width_o = width_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/echo_filter_mc.sv
// Multi-channel echo filter: N_CH independent channel filters whose
// per-channel results are packed onto flat buses for sensor_top.
module echo_filter_mc
   import echo_filter_mc_pkg::*;
#(
   parameter int N_CH        = ECHO_N_CH,
   parameter int FILT_LEN    = ECHO_FILT_LEN,
   parameter int SYNC_STAGES = ECHO_SYNC_STAGES,
   parameter int WIDTH_W     = ECHO_WIDTH_W
)
(
   input  logic                    clk_sys,
   input  logic                    rst,
   input  logic [N_CH-1:0]         ch_en,
   input  logic [N_CH-1:0]         echo_in,
   output logic [N_CH-1:0]         echo_lvl,
   output logic [N_CH-1:0]         echo_rise,
   output logic [N_CH-1:0]         echo_fall,
   output logic [N_CH-1:0]         width_vld,
   output logic [N_CH*WIDTH_W-1:0] width_out,
   output logic [N_CH-1:0]         width_ovf
);

   for (genvar i = 0; i < N_CH; i++) begin : gCh
      echo_filter_ch #(
         .FILT_LEN    (FILT_LEN),
         .SYNC_STAGES (SYNC_STAGES),
         .WIDTH_W     (WIDTH_W)
      ) uCh (
         .clk_sys (clk_sys),
         .rst     (rst),
         .en_i    (ch_en[i]),
         .echo_i  (echo_in[i]),
         .lvl_o   (echo_lvl[i]),
         .rise_o  (echo_rise[i]),
         .fall_o  (echo_fall[i]),
         .vld_o   (width_vld[i]),
         .width_o (width_out[i*WIDTH_W +: WIDTH_W]),
         .ovf_o   (width_ovf[i])
      );
   end

endmodule

// File: tb/tb_echo_filter_mc.sv
// Testbench for echo_filter_mc: directed scenarios plus randomized pulse
// trains, every cycle compared against a behavioural model of the filter.
module tb_echo_filter_mc;

   localparam int N  = 4;
   localparam int F  = 16;
   localparam int S  = 2;
   localparam int W  = 16;
   localparam int WMAX = (1 << W) - 1;

   logic             clk_sys;
   logic             rst;
   logic [N-1:0]     ch_en;
   logic [N-1:0]     echo_in;
   logic [N-1:0]     echo_lvl;
   logic [N-1:0]     echo_rise;
   logic [N-1:0]     echo_fall;
   logic [N-1:0]     width_vld;
   logic [N*W-1:0]   width_out;
   logic [N-1:0]     width_ovf;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 0;

   echo_filter_mc #(
      .N_CH        (N),
      .FILT_LEN    (F),
      .SYNC_STAGES (S),
      .WIDTH_W     (W)
   ) dut (
      .clk_sys   (clk_sys),
      .rst       (rst),
      .ch_en     (ch_en),
      .echo_in   (echo_in),
      .echo_lvl  (echo_lvl),
      .echo_rise (echo_rise),
      .echo_fall (echo_fall),
      .width_vld (width_vld),
      .width_out (width_out),
      .width_ovf (width_ovf)
   );

   // Free-running 10 ns system clock.
   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   // Behavioural model: the raw input reaches the filter S edges later; the level
   // flips once the last F enabled samples all disagree with it; the reported width
   // is the number of cycles the level stayed high, clamped to the counter range.
   bit          mPipe [N][S];
   bit          mHist [N][F];
   int          mHistLen [N];
   bit          mLvl [N];
   int          mHigh [N];
   logic [N-1:0]   expLvl, expRise, expFall, expVld, expOvf;
   logic [N*W-1:0] expWidth;

   // Advance the reference model on every clock edge using the inputs stable at that edge.
   always @(posedge clk_sys) begin : modelProc
      bit sOld;
      bit flip;
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            for (int k = 0; k < S; k++) mPipe[i][k] = 1'b0;
            mHistLen[i] = 0;
            mLvl[i] = 1'b0;
            mHigh[i] = 0;
            expLvl[i] = 1'b0; expRise[i] = 1'b0; expFall[i] = 1'b0;
            expVld[i] = 1'b0; expOvf[i] = 1'b0;
            expWidth[i*W +: W] = '0;
         end else begin
            sOld = mPipe[i][S-1];
            for (int k = S-1; k > 0; k--) mPipe[i][k] = mPipe[i][k-1];
            mPipe[i][0] = echo_in[i];
            expRise[i] = 1'b0; expFall[i] = 1'b0; expVld[i] = 1'b0;
            if (!ch_en[i]) begin
               mLvl[i] = 1'b0;
               mHistLen[i] = 0;
               mHigh[i] = 0;
            end else begin
               for (int k = F-1; k > 0; k--) mHist[i][k] = mHist[i][k-1];
               mHist[i][0] = sOld;
               if (mHistLen[i] < F) mHistLen[i]++;
               flip = (mHistLen[i] == F);
               for (int k = 0; k < F; k++) if (mHist[i][k] == mLvl[i]) flip = 1'b0;
               if (flip) begin
                  mLvl[i] = !mLvl[i];
                  mHistLen[i] = 0;
                  if (mLvl[i]) begin
                     expRise[i] = 1'b1;
                     mHigh[i] = 1;
                  end else begin
                     expFall[i] = 1'b1;
                     expVld[i] = 1'b1;
                     expWidth[i*W +: W] = W'((mHigh[i] > WMAX) ? WMAX : mHigh[i]);
                     expOvf[i] = (mHigh[i] > WMAX);
                  end
               end else if (mLvl[i]) begin
                  mHigh[i]++;
               end
            end
            expLvl[i] = mLvl[i];
         end
      end
   end

   int riseCnt [N];
   int fallCnt [N];
   int vldCnt [N];
   int vldNotFall = 0;

   // Compare every output against the model each cycle and keep strobe tallies for directed checks.
   always @(negedge clk_sys) begin
      if (checkEn) begin
         checkOutput("lvl", 64'(echo_lvl), 64'(expLvl));
         checkOutput("rise", 64'(echo_rise), 64'(expRise));
         checkOutput("fall", 64'(echo_fall), 64'(expFall));
         checkOutput("vld", 64'(width_vld), 64'(expVld));
         checkOutput("width", 64'(width_out), 64'(expWidth));
         checkOutput("ovf", 64'(width_ovf), 64'(expOvf));
         for (int i = 0; i < N; i++) begin
            if (echo_rise[i]) riseCnt[i]++;
            if (echo_fall[i]) fallCnt[i]++;
            if (width_vld[i]) vldCnt[i]++;
            if (width_vld[i] != echo_fall[i]) vldNotFall++;
         end
      end
   end

   // Randomized pulse trains: mostly accepted pulses, some glitches, occasional enable toggles.
   task automatic applyStimulus(input int cycles);
      int holdLeft [N];
      for (int i = 0; i < N; i++) holdLeft[i] = $urandom_range(1, 40);
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            holdLeft[i]--;
            if (holdLeft[i] <= 0) begin
               echo_in[i] = ~echo_in[i];
               holdLeft[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : $urandom_range(14, 120);
            end
         end
         if ($urandom_range(0, 299) == 0) ch_en[$urandom_range(0, N-1)] ^= 1'b1;
         waitCycles(1);
      end
   endtask

   // Hard stop in case something stalls the directed sequence.
   initial begin
      #950000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainSeq
      int r0, r2, f3, v3;
      bit found;
      rst = 1'b1;
      ch_en = 4'hF;
      echo_in = 4'hF;
      @(posedge clk_sys);
      #1;
      checkEn = 1'b1;
      waitCycles(2);
      checkOutput("resetLvl", 64'(echo_lvl), 64'h0);
      checkOutput("resetRise", 64'(echo_rise), 64'h0);
      checkOutput("resetWidth", 64'(width_out), 64'h0);
      checkOutput("resetOvf", 64'(width_ovf), 64'h0);
      rst = 1'b0;
      waitCycles(17);
      checkOutput("lvlBefore18", 64'(echo_lvl), 64'h0);
      waitCycles(1);
      checkOutput("lvlAt18", 64'(echo_lvl), 64'hF);
      checkOutput("riseAt18", 64'(echo_rise), 64'hF);
      waitCycles(1);
      checkOutput("riseOneCycle", 64'(echo_rise), 64'h0);
      echo_in = 4'h0;
      waitCycles(40);

      r0 = riseCnt[0];
      echo_in[0] = 1'b1;
      waitCycles(15);
      echo_in[0] = 1'b0;
      waitCycles(40);
      checkOutput("glitch15Rise", 64'(riseCnt[0] - r0), 64'd0);
      echo_in[0] = 1'b1;
      waitCycles(16);
      echo_in[0] = 1'b0;
      waitCycles(40);
      checkOutput("pulse16Rise", 64'(riseCnt[0] - r0), 64'd1);
      checkOutput("pulse16Width", 64'(width_out[15:0]), 64'd16);

      echo_in[1] = 1'b1;
      waitCycles(1000);
      echo_in[1] = 1'b0;
      waitCycles(30);
      checkOutput("width1000", 64'(width_out[31:16]), 64'd1000);
      checkOutput("width1000Ovf", 64'(width_ovf[1]), 64'd0);

      echo_in[2] = 1'b1;
      waitCycles(70000);
      echo_in[2] = 1'b0;
      waitCycles(30);
      checkOutput("satWidth", 64'(width_out[47:32]), 64'hFFFF);
      checkOutput("satOvf", 64'(width_ovf[2]), 64'd1);
      echo_in[2] = 1'b1;
      waitCycles(50);
      echo_in[2] = 1'b0;
      waitCycles(30);
      checkOutput("afterSatWidth", 64'(width_out[47:32]), 64'd50);
      checkOutput("afterSatOvf", 64'(width_ovf[2]), 64'd0);

      echo_in[3] = 1'b1;
      waitCycles(120);
      echo_in[3] = 1'b0;
      waitCycles(30);
      echo_in[3] = 1'b1;
      waitCycles(30);
      checkOutput("enDropLvlBefore", 64'(echo_lvl[3]), 64'd1);
      f3 = fallCnt[3];
      v3 = vldCnt[3];
      ch_en[3] = 1'b0;
      waitCycles(1);
      checkOutput("enDropLvl", 64'(echo_lvl[3]), 64'd0);
      waitCycles(30);
      checkOutput("enDropFall", 64'(fallCnt[3] - f3), 64'd0);
      checkOutput("enDropVld", 64'(vldCnt[3] - v3), 64'd0);
      checkOutput("enDropWidth", 64'(width_out[63:48]), 64'd120);
      echo_in[3] = 1'b0;
      ch_en[3] = 1'b1;
      waitCycles(30);

      r2 = riseCnt[2];
      for (int c = 0; c < 300; c++) begin
         echo_in[1] = 1'b1;
         if (c >= 100) echo_in[0] = 1'b1;
         echo_in[2] = ((c / 8) % 2) == 1;
         waitCycles(1);
      end
      echo_in[2:0] = 3'b000;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         waitCycles(1);
         if (width_vld[0]) found = 1'b1;
      end
      checkOutput("indepVldSeen", 64'(found), 64'd1);
      if (found) begin
         checkOutput("indepVldBoth", 64'(width_vld[1:0]), 64'h3);
         checkOutput("indepWidth0", 64'(width_out[15:0]), 64'd200);
         checkOutput("indepWidth1", 64'(width_out[31:16]), 64'd300);
      end
      waitCycles(30);
      checkOutput("chatterRise", 64'(riseCnt[2] - r2), 64'd0);

      applyStimulus(3000);
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      ch_en = 4'hF;
      applyStimulus(3000);
      echo_in = 4'h0;
      waitCycles(40);
      checkOutput("vldWithFall", 64'(vldNotFall), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
